// File: rtl/pwm_capture_if.sv
// pwm_capture_if: signal bundle between a PWM capture block and its user.
//
// Signals:
//   en        capture enable (user -> capture)
//   pwm_i     asynchronous PWM input (user -> capture)
//   hi_o      high-phase length of the last completed period
//   lo_o      low-phase length of the last completed period
//   valid_o   one-cycle result strobe
//   stuck_o   sticky phase-overflow flag
//   state_dbg current capture FSM state, for observation only
//
// Handshake: valid_o is a pure strobe with no ready/back-pressure. hi_o/lo_o
// are updated in the same cycle valid_o is high and hold between strobes, so
// a consumer that misses a strobe still sees the latest result.
interface pwm_capture_if #(
    parameter int W = 8
);
    logic         en;
    logic         pwm_i;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         valid_o;
    logic         stuck_o;
    logic [1:0]   state_dbg;

    modport master (
        output en, pwm_i,
        input  hi_o, lo_o, valid_o, stuck_o, state_dbg
    );

    modport slave (
        input  en, pwm_i,
        output hi_o, lo_o, valid_o, stuck_o, state_dbg
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures the high and low phase lengths (in clk cycles) of an
// asynchronous PWM input and reports each completed period as {hi, lo}.
//
// Ports:
//   clk     rising-edge clock
//   arst_n  asynchronous active-low reset
//   bus     pwm_capture_if.slave (en, pwm_i in; hi_o, lo_o, valid_o,
//           stuck_o, state_dbg out)
//
// Parameters:
//   W           counter / result width, MAX = 2^W-1
//   SYNC_STAGES synchronizer depth (>= 2)
//   FILTER_LEN  deglitch length, used only with PWM_CAPTURE_FILTER_EN
//
// Optional feature: define PWM_CAPTURE_FILTER_EN to insert a deglitch stage
// between the synchronizer and the edge detector.
module pwm_capture #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic          clk,
    input  logic          arst_n,
    pwm_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEAS_HI = 2'd1,
        MEAS_LO = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX = {W{1'b1}};
    localparam logic [W-1:0] ONE = W'(1);

    // Input synchronizer
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_i};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    logic s;
    logic s_d;

`ifdef PWM_CAPTURE_FILTER_EN
    // s follows the synchronized input only after it has held a new level for
    // FILTER_LEN consecutive cycles; both edges see the same delay, so clean
    // phase lengths are preserved.
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] filt_cnt;
    logic          filt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            filt_cnt <= '0;
            filt_q   <= 1'b0;
        end else if (sync_out == filt_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_q   <= sync_out;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign s = filt_q;
`else
    localparam int unused_filter_len = FILTER_LEN;
    assign s = sync_out;
`endif

    // s_d keeps running while disabled so re-enable never sees a false edge
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    logic rise;
    logic fall;
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Capture FSM
    state_t       state_q, state_n;
    logic [W-1:0] cnt_q, cnt_n;
    logic [W-1:0] hl_q, hl_n;
    logic [W-1:0] hi_q, hi_n;
    logic [W-1:0] lo_q, lo_n;
    logic         valid_q, valid_n;
    logic         stuck_q, stuck_n;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hl_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            hl_q    <= hl_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            valid_q <= valid_n;
            stuck_q <= stuck_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        hl_n    = hl_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        valid_n = 1'b0;
        stuck_n = stuck_q;

        if (!bus.en) begin
            // Abort: the running period is dropped, results and stuck hold
            state_n = IDLE;
            cnt_n   = '0;
            hl_n    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Wait for a rising edge so only whole periods are measured
                    cnt_n = '0;
                    if (rise) begin
                        cnt_n   = ONE;
                        state_n = MEAS_HI;
                    end
                end
                MEAS_HI: begin
                    if (fall) begin
                        hl_n    = cnt_q;
                        cnt_n   = ONE;
                        state_n = MEAS_LO;
                    end else if (cnt_q == MAX) begin
                        stuck_n = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                MEAS_LO: begin
                    if (rise) begin
                        hi_n    = hl_q;
                        lo_n    = cnt_q;
                        valid_n = 1'b1;
                        stuck_n = 1'b0;
                        cnt_n   = ONE;
                        state_n = MEAS_HI;
                    end else if (cnt_q == MAX) begin
                        stuck_n = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
    assign bus.valid_o   = valid_q;
    assign bus.stuck_o   = stuck_q;
    assign bus.state_dbg = state_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- PWM decoder: measures the high-phase and low-phase length, in clk cycles, of an incoming PWM waveform.
- Reports each completed period as an {hi, lo} pair using the same encoding the pwm generator accepts.
- Sits on the input side of boards driving our pwm block; also used for loopback self-check against pwm_o.

Parameters:
- W, 8, width of hi_o/lo_o and of the internal phase counter; max reportable phase length MAX = 2^W-1.
- SYNC_STAGES, 2, flip-flop depth of the pwm_i synchronizer; legal range is 2 or more.
- FILTER_LEN, 3, deglitch length in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock; every register is on its rising edge
- arst_n  in  1  asynchronous active-low reset
- en  in  1  capture enable; low aborts and idles the block
- pwm_i  in  1  asynchronous PWM input
- hi_o  out  W  high-phase length of the last completed period
- lo_o  out  W  low-phase length of the last completed period
- valid_o  out  1  one-cycle strobe; hi_o/lo_o updated in the same cycle
- stuck_o  out  1  sticky flag: a phase exceeded MAX cycles

Behaviour:
- Reset (arst_n=0, asynchronous): hi_o=0, lo_o=0, valid_o=0, stuck_o=0; synchronizer regs=0, state=IDLE, counter=0.
- Input path: pwm_i passes through the SYNC_STAGES synchronizer to give s. s_d is s delayed one cycle.
- Edge detect: rise = s & ~s_d; fall = ~s & s_d. rise and fall are mutually exclusive.
- Counting rule: a phase length is the number of cycles s holds that level. Output is exact for any phase from 1 to MAX cycles.
- FSM, all transitions gated by en=1:
  - IDLE: counter held at 0. On rise: counter=1, go to MEAS_HI. The first partial period after reset, enable or stuck is discarded.
  - MEAS_HI:
    - s=1 and counter<MAX: counter+1.
    - fall: hi_latch=counter, counter=1, go to MEAS_LO.
    - s=1 and counter==MAX: stuck_o=1, go to IDLE.
  - MEAS_LO:
    - s=0 and counter<MAX: counter+1.
    - rise: hi_o=hi_latch, lo_o=counter, valid_o=1 for one cycle, stuck_o=0, counter=1, go to MEAS_HI.
    - s=0 and counter==MAX: stuck_o=1, go to IDLE.
- Latency: valid_o goes high at the (SYNC_STAGES+1)th clk edge that samples pwm_i high at the end of a low phase. With defaults this is 3 edges.
- Throughput: one result per PWM period. The minimum period hi=1, lo=1 is supported, giving back-to-back valid_o every 2 cycles.
- en=0, any state:
  - Go to IDLE next cycle and clear counter and hi_latch; valid_o=0.
  - hi_o, lo_o and stuck_o hold their values.
  - The synchronizer and s_d keep running, so no false edge occurs on re-enable.
- en deasserted mid-period: that period is never reported.
- stuck_o: set on phase overflow; cleared only by the next valid_o or by reset.
- A phase of exactly MAX cycles is reported normally. MAX+1 cycles is flagged as stuck.
- hi_o/lo_o change only in cycles where valid_o=1.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - A deglitch stage sits between the synchronizer and s.
  - s changes only after the synchronized input has held the new level for FILTER_LEN consecutive cycles.
  - Pulses shorter than FILTER_LEN are ignored and merge into the surrounding phase.
  - Phase lengths of clean inputs are unchanged, because both edges are delayed equally.
  - Latency grows by FILTER_LEN cycles. The minimum measurable phase becomes FILTER_LEN.
- Undefined: s is the synchronizer output directly, with no extra logic or latency.

Test Plan:
- Reset held 20 cycles, then released with en=1, pwm_i=0 -> all outputs 0, no valid_o, stuck_o=0.
- pwm_i square wave with 5 cycles high and 11 low, repeated -> first partial period dropped; each later period gives valid_o with hi_o=5, lo_o=11, one strobe per 16 cycles.
- Waveform switches mid-run to 8/12, then to 2/8 -> one transitional result (mixed lengths allowed); afterwards results are exactly 8/12, then 2/8; hi_o/lo_o are stable between strobes.
- Boundary lengths 1/1, then 255/1 with W=8 -> 1/1 strobed every 2 cycles; 255/1 reported, stuck_o=0.
- pwm_i held high 300 cycles, then 4/4 -> stuck_o=1 when the counter passes 255, no valid_o during the stuck time; stuck_o clears at the first 4/4 valid_o.
- en dropped for 10 cycles during a high phase of a 5/11 wave, and arst_n pulsed mid-period -> the interrupted period is never reported; after recovery the first full period reports 5/11. With PWM_CAPTURE_FILTER_EN and FILTER_LEN=3: 1-cycle glitches injected into 5/11 are ignored and 5/11 is still reported.
